spi_reg_slave: RTL and testbench
================================

# spi_reg_slave

SPI responder that exposes a bank of 8-bit registers to an SPI master over MOSI/MISO/SPI_SCLK/CS. Each frame starts with a command byte (read/write plus start address), followed by any number of data bytes with auto-incrementing address. It sits on the far end of the serial link from `spi_master`, replacing the raw-shift `spi_slave` where addressed register access is needed. A local parallel port lets on-chip logic read and write the same registers.

## Interface

- ADDR_W, 4, register address width; bank holds 2^ADDR_W registers; legal range 1..7
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- SPI_SCLK  input  1  serial clock from master, asynchronous to clk
- CS  input  1  chip select, active low
- MOSI  input  1  serial data in, MSB first
- MISO  output  1  serial data out, MSB first; 0 when CS high
- CPOL  input  1  SCLK idle level; static while CS low
- CPHA  input  1  0: sample on leading edge, 1: sample on trailing edge; static while CS low
- busy  output  1  high while a frame is active (CS low, synchronised)
- wr_stb  output  1  one-clk pulse per SPI-written data byte
- wr_addr  output  ADDR_W  address of the SPI write; valid with wr_stb
- wr_data  output  8  data of the SPI write; valid with wr_stb
- loc_we  input  1  local write enable
- loc_addr  input  ADDR_W  local read/write address
- loc_wdata  input  8  local write data
- loc_rdata  output  8  combinational read of reg[loc_addr]

## Operation

- SPI_SCLK, CS, MOSI each pass a 2-FF synchroniser; SCLK edges detected on synchronised signal. Leading edge = transition away from CPOL; trailing = back to CPOL.
- States: IDLE, CMD, DATA.
  - IDLE: MISO=0, bit counter=0. Synchronised CS falling -> CMD.
  - CMD: sample 8 MOSI bits on sample edges. On 8th sample: rw=bit7 (1=read), addr=bits[ADDR_W-1:0], other bits ignored; load tx byte = reg[addr] if read, else 0x00 -> DATA.
  - DATA, write: on each 8th sample, reg[addr] <= byte, pulse wr_stb with addr/data, addr <= addr+1.
  - DATA, read: MOSI ignored; on each 8th sample, addr <= addr+1 and tx byte reloaded from reg[addr+1] at that instant.
- MISO: CPHA=0 presents bit 7 from byte load, bit i-1 from trailing edge ending bit i. CPHA=1 presents bit i from leading edge of bit i. MISO=0 during CMD and during write frames.
- Address increment wraps modulo 2^ADDR_W (15 -> 0 for ADDR_W=4).
- CS deasserted (synchronised) in any state -> IDLE immediately; partial byte discarded, no write, no wr_stb.
- Local write: loc_we writes reg[loc_addr] <= loc_wdata at next clk edge. Same-cycle collision with SPI write to same address: SPI wins. Different addresses: both complete.
- rst low (any time, including mid-frame): all registers 0x00, state IDLE, MISO=0, busy=0, wr_stb=0, wr_addr=0, wr_data=0, counters 0.

## Timing

- Synchroniser + edge detect: 3 clk from SCLK/CS pin change to internal action.
- MISO update ≤ 4 clk after the corresponding SCLK edge; required: SCLK half-period ≥ 8 clk, CS-low to first SCLK edge ≥ 8 clk, CS high between frames ≥ 4 clk.
- wr_stb asserted exactly one clk, the cycle after the 8th sample edge is detected; register content updated on that same edge (loc_rdata shows new value the following cycle).
- busy rises 3 clk after CS falls, falls 3 clk after CS rises.
- Read byte content is the register value at the sample edge completing the previous byte; later local writes in that byte do not affect the bits being shifted.

## Test plan

- Mode 0 write: CS low, MOSI 0x03, 0xA5, 0x3C, CS high -> reg[3]=0xA5, reg[4]=0x3C; two wr_stb pulses (addr 3/0xA5, addr 4/0x3C).
- Mode 0 read after the above: MOSI 0x83, 0x00, 0x00 -> MISO bytes 0x00, 0xA5, 0x3C; no wr_stb.
- Wrap: write command 0x0F then 0x11, 0x22, 0x33 -> reg[15]=0x11, reg[0]=0x22, reg[1]=0x33.
- Abort: write 0x05, 0xFF, then 4 more SCLK cycles, CS high -> reg[5]=0xFF, reg[6] unchanged, one wr_stb only, busy returns 0; next frame decodes normally.
- Mode 3 (CPOL=1, CPHA=1) and mode 1: local write reg[7]=0x5A, SPI read 0x87,0x00 -> MISO data byte 0x5A in both modes.
- Collision and reset: loc_we to reg[2] in the wr_stb cycle of SPI write 0x02/0x77 -> reg[2]=0x77; rst low mid-byte -> all regs 0x00, MISO=0, busy=0.

Source files
------------

// File: rtl/spi_reg_slave.sv
// SPI register responder: command byte (rw + start address) followed by auto-incrementing data bytes.
// Register bank is shared with a local parallel port; an SPI write wins a same-address collision.
//
// state | meaning
// IDLE  | CS high, MISO held low, bit counter cleared
// CMD   | shifting in the command byte
// DATA  | streaming data bytes, address advances after each byte
module spi_reg_slave #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SPI_SCLK,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              CPOL,
    input  logic              CPHA,
    output logic              busy,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [7:0]        loc_wdata,
    output logic [7:0]        loc_rdata
);

    localparam int NREG = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t            state;
    logic [2:0]        sclk_sync;
    logic [1:0]        cs_sync;
    logic [1:0]        mosi_sync;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_sr;
    logic [7:0]        tx_sr;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        regs [NREG];

    logic              cs_high;
    logic              lead_edge;
    logic              trail_edge;
    logic              sample;
    logic              shift;
    logic              last_bit;
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_nxt;
    logic              spi_we;
    logic [7:0]        load_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= 2'b11;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], SPI_SCLK};
            cs_sync   <= {cs_sync[0], CS};
            mosi_sync <= {mosi_sync[0], MOSI};
        end
    end

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign cs_high    = cs_sync[1];
    assign lead_edge  = (sclk_sync[1] != CPOL) && (sclk_sync[2] == CPOL);
    assign trail_edge = (sclk_sync[1] == CPOL) && (sclk_sync[2] != CPOL);
    assign sample     = CPHA ? trail_edge : lead_edge;
    assign shift      = CPHA ? lead_edge : trail_edge;
    assign last_bit   = (bit_cnt == 3'd7);
    assign rx_byte    = {rx_sr, mosi_sync[1]};
    assign addr_nxt   = addr + ADDR_W'(1);
    assign spi_we     = (state == DATA) && !cs_high && sample && last_bit && !rw;
    assign loc_rdata  = regs[loc_addr];

    // Byte to shift out next, captured at the sample edge that completes the current byte.
    always_comb begin
        load_val = 8'h00;
        if (state == CMD) begin
            if (rx_byte[7]) load_val = regs[rx_byte[ADDR_W-1:0]];
        end else if (rw) begin
            load_val = regs[addr_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
            rw      <= 1'b0;
            addr    <= '0;
            MISO    <= 1'b0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (cs_high) begin
                state   <= IDLE;
                bit_cnt <= '0;
                tx_sr   <= '0;
                MISO    <= 1'b0;
                busy    <= 1'b0;
            end else if (state == IDLE) begin
                state   <= CMD;
                bit_cnt <= '0;
                tx_sr   <= '0;
                MISO    <= 1'b0;
                busy    <= 1'b1;
            end else if (sample) begin
                rx_sr   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (last_bit) begin
                    state <= DATA;
                    if (state == CMD) begin
                        rw   <= rx_byte[7];
                        addr <= rx_byte[ADDR_W-1:0];
                    end else begin
                        addr <= addr_nxt;
                        if (!rw) begin
                            wr_stb  <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= rx_byte;
                        end
                    end
                    // With CPHA=0 the master samples on the leading edge, so bit 7 goes out right away.
                    if (!CPHA) begin
                        MISO  <= load_val[7];
                        tx_sr <= {load_val[6:0], 1'b0};
                    end else begin
                        tx_sr <= load_val;
                    end
                end
            end else if (shift && (CPHA || bit_cnt != 3'd0)) begin
                MISO  <= tx_sr[7];
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (spi_we && addr == ADDR_W'(i))
                    regs[i] <= rx_byte;
                else if (loc_we && loc_addr == ADDR_W'(i))
                    regs[i] <= loc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: a table of SPI frames with expected MISO bytes, strobe
// counts and register contents, plus hand sequences for busy timing, abort, collision and reset.
module tb_spi_reg_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       SPI_SCLK;
    logic       CS;
    logic       MOSI;
    logic       MISO;
    logic       CPOL;
    logic       CPHA;
    logic       busy;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       loc_we;
    logic [3:0] loc_addr;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;

    int tests = 0;
    int fails = 0;
    logic [11:0] stb_q[$];

    spi_reg_slave #(.ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .SPI_SCLK(SPI_SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
        .CPOL(CPOL), .CPHA(CPHA), .busy(busy), .wr_stb(wr_stb), .wr_addr(wr_addr),
        .wr_data(wr_data), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .loc_rdata(loc_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_stb) stb_q.push_back({wr_addr, wr_data});

    typedef struct {
        logic            cpol;
        logic            cpha;
        int              nbytes;
        logic [3:0][7:0] mosi;
        logic [3:0][7:0] miso;
        int              nstb;
        logic [3:0]      chk_addr;
        logic [7:0]      chk_val;
    } frame_t;

    frame_t vec[6];

    function automatic logic [3:0][7:0] pack4(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
        loc_addr = a;
        #1;
        check(name, {24'h0, loc_rdata}, {24'h0, exp});
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
        loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        wait_n(1);
        loc_we = 1'b0;
    endtask

    // One SPI byte, master side; SCLK half-period is 10 clk. coll=1 drives a local write
    // timed to land on the same clk edge as the SPI write of this byte (mode 0 only).
    task automatic spi_byte(input logic [7:0] tx, input bit coll, input logic [3:0] ca,
                            input logic [7:0] cd, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            if (!CPHA) begin
                MOSI = tx[i];
                wait_n(10);
                rx[i] = MISO;
                SPI_SCLK = ~CPOL;
                if (coll && i == 0) begin
                    wait_n(2);
                    loc_we = 1'b1; loc_addr = ca; loc_wdata = cd;
                    wait_n(1);
                    loc_we = 1'b0;
                    check("coll_stb_align", {31'h0, wr_stb}, 32'h1);
                    wait_n(7);
                end else begin
                    wait_n(10);
                end
                SPI_SCLK = CPOL;
            end else begin
                SPI_SCLK = ~CPOL;
                MOSI = tx[i];
                wait_n(10);
                rx[i] = MISO;
                SPI_SCLK = CPOL;
                wait_n(10);
            end
        end
    endtask

    task automatic frame_start(input logic cpol, input logic cpha);
        CPOL = cpol; CPHA = cpha; SPI_SCLK = cpol;
        wait_n(8);
        CS = 1'b0;
        wait_n(10);
        check("busy_in_frame", {31'h0, busy}, 32'h1);
    endtask

    task automatic frame_end();
        wait_n(10);
        CS = 1'b1; MOSI = 1'b0;
        wait_n(8);
        check("busy_after_frame", {31'h0, busy}, 32'h0);
    endtask

    task automatic run_frame(input frame_t f, input int coll_byte, input logic [3:0] ca,
                             input logic [7:0] cd, output logic [3:0][7:0] rx);
        logic [7:0] b;
        rx = '0;
        frame_start(f.cpol, f.cpha);
        for (int k = 0; k < f.nbytes; k++) begin
            spi_byte(f.mosi[k], (k == coll_byte), ca, cd, b);
            rx[k] = b;
        end
        frame_end();
    endtask

    initial begin
        logic [3:0][7:0] rx;
        logic [7:0] b;
        int q0;
        frame_t f;

        vec[0] = '{1'b0, 1'b0, 3, pack4(8'h03, 8'hA5, 8'h3C, 8'h00), pack4(8'h00, 8'h00, 8'h00, 8'h00), 2, 4'h4, 8'h3C};
        vec[1] = '{1'b0, 1'b0, 3, pack4(8'h83, 8'h00, 8'h00, 8'h00), pack4(8'h00, 8'hA5, 8'h3C, 8'h00), 0, 4'h3, 8'hA5};
        vec[2] = '{1'b0, 1'b0, 4, pack4(8'h0F, 8'h11, 8'h22, 8'h33), pack4(8'h00, 8'h00, 8'h00, 8'h00), 3, 4'h0, 8'h22};
        vec[3] = '{1'b1, 1'b0, 4, pack4(8'h8F, 8'h00, 8'h00, 8'h00), pack4(8'h00, 8'h11, 8'h22, 8'h33), 0, 4'hF, 8'h11};
        vec[4] = '{1'b1, 1'b1, 2, pack4(8'h87, 8'h00, 8'h00, 8'h00), pack4(8'h00, 8'h5A, 8'h00, 8'h00), 0, 4'h1, 8'h33};
        vec[5] = '{1'b0, 1'b1, 2, pack4(8'h87, 8'h00, 8'h00, 8'h00), pack4(8'h00, 8'h5A, 8'h00, 8'h00), 0, 4'h7, 8'h5A};

        rst = 1'b0; SPI_SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0; CPOL = 1'b0; CPHA = 1'b0;
        loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
        wait_n(3);
        check("rst_miso", {31'h0, MISO}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
        check("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
        check_reg("rst_reg0", 4'h0, 8'h00);
        rst = 1'b1;
        wait_n(3);

        // busy follows CS with a 3-clk lag in both directions
        CS = 1'b0;
        wait_n(2);
        check("busy_rise_early", {31'h0, busy}, 32'h0);
        wait_n(1);
        check("busy_rise", {31'h0, busy}, 32'h1);
        wait_n(7);
        CS = 1'b1;
        wait_n(2);
        check("busy_fall_early", {31'h0, busy}, 32'h1);
        wait_n(1);
        check("busy_fall", {31'h0, busy}, 32'h0);
        wait_n(5);

        loc_write(4'h7, 8'h5A);
        check_reg("loc_write_reg7", 4'h7, 8'h5A);

        for (int v = 0; v < 6; v++) begin
            q0 = stb_q.size();
            run_frame(vec[v], -1, 4'h0, 8'h00, rx);
            for (int k = 0; k < vec[v].nbytes; k++)
                check($sformatf("vec%0d_miso%0d", v, k), {24'h0, rx[k]}, {24'h0, vec[v].miso[k]});
            check($sformatf("vec%0d_nstb", v), stb_q.size() - q0, vec[v].nstb);
            check_reg($sformatf("vec%0d_reg", v), vec[v].chk_addr, vec[v].chk_val);
        end
        check("stb0", {20'h0, stb_q[0]}, {20'h0, 12'h3A5});
        check("stb1", {20'h0, stb_q[1]}, {20'h0, 12'h43C});
        check("stb_wrap", {20'h0, stb_q[3]}, {20'h0, 12'h022});
        check_reg("wrap_reg15", 4'hF, 8'h11);
        check_reg("wrap_reg1", 4'h1, 8'h33);

        // abort mid-byte: the partial byte must not be written
        q0 = stb_q.size();
        frame_start(1'b0, 1'b0);
        spi_byte(8'h05, 1'b0, 4'h0, 8'h00, b);
        spi_byte(8'hFF, 1'b0, 4'h0, 8'h00, b);
        for (int i = 0; i < 4; i++) begin
            MOSI = 1'b1; wait_n(10); SPI_SCLK = 1'b1; wait_n(10); SPI_SCLK = 1'b0;
        end
        frame_end();
        check("abort_nstb", stb_q.size() - q0, 1);
        check_reg("abort_reg5", 4'h5, 8'hFF);
        check_reg("abort_reg6", 4'h6, 8'h00);
        f = '{1'b0, 1'b0, 3, pack4(8'h85, 8'h00, 8'h00, 8'h00), pack4(8'h00, 8'h00, 8'h00, 8'h00), 0, 4'h0, 8'h00};
        run_frame(f, -1, 4'h0, 8'h00, rx);
        check("after_abort_rd5", {24'h0, rx[1]}, 32'hFF);
        check("after_abort_rd6", {24'h0, rx[2]}, 32'h00);

        // same-cycle collisions: same address -> SPI wins; different addresses -> both land
        f = '{1'b0, 1'b0, 2, pack4(8'h02, 8'h77, 8'h00, 8'h00), pack4(8'h00, 8'h00, 8'h00, 8'h00), 1, 4'h2, 8'h77};
        run_frame(f, 1, 4'h2, 8'hEE, rx);
        wait_n(1);
        check_reg("coll_same_reg2", 4'h2, 8'h77);
        f = '{1'b0, 1'b0, 2, pack4(8'h0A, 8'h44, 8'h00, 8'h00), pack4(8'h00, 8'h00, 8'h00, 8'h00), 1, 4'hA, 8'h44};
        run_frame(f, 1, 4'hB, 8'h99, rx);
        check_reg("coll_diff_reg10", 4'hA, 8'h44);
        check_reg("coll_diff_reg11", 4'hB, 8'h99);

        // reset during a read of reg7 (0x5A) with MISO driving bit 6 = 1
        frame_start(1'b0, 1'b0);
        spi_byte(8'h87, 1'b0, 4'h0, 8'h00, b);
        MOSI = 1'b0; wait_n(10); SPI_SCLK = 1'b1; wait_n(10); SPI_SCLK = 1'b0;
        wait_n(5);
        check("pre_rst_miso_bit6", {31'h0, MISO}, 32'h1);
        rst = 1'b0;
        wait_n(1);
        check("midrst_miso", {31'h0, MISO}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_wr_addr", {28'h0, wr_addr}, 32'h0);
        check("midrst_wr_data", {24'h0, wr_data}, 32'h0);
        for (int a = 0; a < 16; a++)
            check_reg($sformatf("midrst_reg%0d", a), 4'(a), 8'h00);
        CS = 1'b1;
        wait_n(5);
        rst = 1'b1;
        wait_n(5);
        check("post_rst_busy", {31'h0, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
